// File: rtl/udp_packet_builder_n6.sv
// Ethernet/IPv4/UDP frame serialiser: one header descriptor plus a payload word stream in, 32-bit packet bus out.
// Optional macro PKT_BUILDER_IPV4_CSUM_EN enables the IPv4 header checksum (otherwise the field is emitted as 0).
module udp_packet_builder_n6 #(
  parameter int unsigned MAX_PAYLOAD_B = 1472,
  parameter logic [15:0] IP_ID_INIT    = 16'h0000,
  parameter logic [15:0] ETHERTYPE     = 16'h0800
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        hdr_valid_i,
  output logic        hdr_ready_o,
  input  logic [47:0] dst_mac_i,
  input  logic [47:0] src_mac_i,
  input  logic [31:0] src_ip_i,
  input  logic [31:0] dst_ip_i,
  input  logic [7:0]  tos_i,
  input  logic [7:0]  ttl_i,
  input  logic [15:0] src_port_i,
  input  logic [15:0] dst_port_i,
  input  logic [15:0] pay_len_i,
  input  logic [31:0] pay_data_i,
  input  logic        pay_valid_i,
  input  logic        pay_last_i,
  output logic        pay_ready_o,
  output logic [31:0] tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        tx_sop_o,
  output logic        tx_eop_o,
  output logic [2:0]  tx_bytes_o,
  output logic        len_err_o
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD_B);

  typedef enum logic [2:0] {S_IDLE, S_CSUM, S_HDR, S_PAYLOAD, S_TAIL} state_e;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [7:0]  tos;
    logic [7:0]  ttl;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] pay_len;
  } desc_t;

  state_e      state_q, state_d;
  desc_t       desc_q, desc_d;
  logic [3:0]  word_q, word_d;
  logic [14:0] pay_cnt_q, pay_cnt_d;
  logic [15:0] carry_q, carry_d;
  logic [15:0] ip_id_q, ip_id_d;
  logic [15:0] csum_q, csum_d;
  logic        len_err_q, len_err_d;
  logic        err_seen_q, err_seen_d;

  logic [16:0]  len_p3;
  logic [14:0]  nw;
  logic         last_pay, tail_en, len_bad;
  logic [2:0]   tail_bytes, last_pay_bytes;
  logic [15:0]  tot_len, udp_len, csum_calc;
  logic [319:0] hdr_vec, hdr_sh;
  logic         valid, sop, eop_raw, need_pay;
  logic [2:0]   bytes_raw;
  logic [31:0]  data_raw;
  logic [5:0]   mask_sh;

  assign len_p3         = {1'b0, desc_q.pay_len} + 17'd3;
  assign nw             = len_p3[16:2];
  assign last_pay       = (pay_cnt_q == nw - 15'd1);
  // After the last payload word the 16-bit carry still holds 1 or 2 real bytes when L%4 is 3 or 0.
  assign tail_en        = (desc_q.pay_len[1:0] == 2'd3) || (desc_q.pay_len[1:0] == 2'd0);
  assign tail_bytes     = (desc_q.pay_len[1:0] == 2'd3) ? 3'd1 : 3'd2;
  assign last_pay_bytes = (desc_q.pay_len[1:0] == 2'd1) ? 3'd3 : 3'd4;
  assign len_bad        = (pay_len_i == 16'd0) || (pay_len_i > MAX_LEN);
  assign tot_len        = desc_q.pay_len + 16'd28;
  assign udp_len        = desc_q.pay_len + 16'd8;

  // Header bytes 0..39; bytes 40-41 (UDP checksum, always zero) are merged into word 10.
  assign hdr_vec = {desc_q.dst_mac, desc_q.src_mac, ETHERTYPE,
                    8'h45, desc_q.tos, tot_len, ip_id_q, 16'h0000, desc_q.ttl, 8'd17, csum_q,
                    desc_q.src_ip, desc_q.dst_ip,
                    desc_q.src_port, desc_q.dst_port, udp_len};
  assign hdr_sh  = hdr_vec << {word_q, 5'b00000};

`ifdef PKT_BUILDER_IPV4_CSUM_EN
  logic [19:0] csum_sum;
  logic [16:0] csum_f1;
  logic [15:0] csum_f2;
  always_comb begin
    csum_sum = {4'h0, 8'h45, desc_q.tos} + {4'h0, tot_len} + {4'h0, ip_id_q}
             + {4'h0, desc_q.ttl, 8'd17}
             + {4'h0, desc_q.src_ip[31:16]} + {4'h0, desc_q.src_ip[15:0]}
             + {4'h0, desc_q.dst_ip[31:16]} + {4'h0, desc_q.dst_ip[15:0]};
    csum_f1   = {1'b0, csum_sum[15:0]} + {13'd0, csum_sum[19:16]};
    csum_f2   = csum_f1[15:0] + {15'd0, csum_f1[16]};
    csum_calc = ~csum_f2;
  end
`else
  assign csum_calc = 16'h0000;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
    state_d     = state_q;
    desc_d      = desc_q;
    word_d      = word_q;
    pay_cnt_d   = pay_cnt_q;
    carry_d     = carry_q;
    ip_id_d     = ip_id_q;
    csum_d      = csum_q;
    len_err_d   = 1'b0;
    err_seen_d  = err_seen_q;
    hdr_ready_o = 1'b0;
    valid       = 1'b0;
    sop         = 1'b0;
    eop_raw     = 1'b0;
    need_pay    = 1'b0;
    bytes_raw   = 3'd4;
    data_raw    = 32'h0;
    case (state_q)
      S_IDLE: begin
        hdr_ready_o = 1'b1;
        if (hdr_valid_i) begin
          if (len_bad) begin
            len_err_d = 1'b1;
          end else begin
            desc_d     = {dst_mac_i, src_mac_i, src_ip_i, dst_ip_i, tos_i, ttl_i,
                          src_port_i, dst_port_i, pay_len_i};
            state_d    = S_CSUM;
            word_d     = 4'd0;
            pay_cnt_d  = 15'd0;
            err_seen_d = 1'b0;
          end
        end
      end
      S_CSUM: begin
        csum_d  = csum_calc;
        state_d = S_HDR;
      end
      S_HDR, S_PAYLOAD: begin
        if (state_q == S_HDR && word_q != 4'd10) begin
          valid    = 1'b1;
          data_raw = hdr_sh[319:288];
          sop      = (word_q == 4'd0);
          if (tx_ready_i) word_d = word_q + 4'd1;
        end else begin
          // Payload-carrying word: never emitted without a payload word behind it.
          need_pay  = 1'b1;
          valid     = pay_valid_i;
          data_raw  = {(state_q == S_HDR) ? 16'h0000 : carry_q, pay_data_i[31:16]};
          eop_raw   = last_pay && !tail_en;
          bytes_raw = eop_raw ? last_pay_bytes : 3'd4;
          if (pay_valid_i && tx_ready_i) begin
            carry_d   = pay_data_i[15:0];
            pay_cnt_d = pay_cnt_q + 15'd1;
            if (!err_seen_q && (pay_last_i != last_pay)) begin
              len_err_d  = 1'b1;
              err_seen_d = 1'b1;
            end
            if (eop_raw)       state_d = S_IDLE;
            else if (last_pay) state_d = S_TAIL;
            else               state_d = S_PAYLOAD;
          end
        end
      end
      S_TAIL: begin
        valid     = 1'b1;
        data_raw  = {carry_q, 16'h0000};
        eop_raw   = 1'b1;
        bytes_raw = tail_bytes;
        if (tx_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (valid && tx_ready_i && eop_raw) ip_id_d = ip_id_q + 16'd1;
  end

  assign mask_sh     = {3'd4 - tx_bytes_o, 3'b000};
  assign pay_ready_o = need_pay && tx_ready_i;
  assign tx_valid_o  = valid;
  assign tx_sop_o    = sop;
  assign tx_eop_o    = eop_raw && valid;
  assign tx_bytes_o  = tx_eop_o ? bytes_raw : 3'd4;
  assign tx_data_o   = valid ? (data_raw & (32'hFFFF_FFFF << mask_sh)) : 32'h0;
  assign len_err_o   = len_err_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= S_IDLE;
      word_q     <= 4'd0;
      pay_cnt_q  <= 15'd0;
      carry_q    <= 16'h0;
      ip_id_q    <= IP_ID_INIT;
      csum_q     <= 16'h0;
      len_err_q  <= 1'b0;
      err_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      pay_cnt_q  <= pay_cnt_d;
      carry_q    <= carry_d;
      ip_id_q    <= ip_id_d;
      csum_q     <= csum_d;
      len_err_q  <= len_err_d;
      err_seen_q <= err_seen_d;
    end
  end

  // NOTE: descriptor fields are pure datapath, loaded before use, so they carry no reset.
  always_ff @(posedge CLK) begin
    desc_q <= desc_d;
  end

endmodule

// File: tb/tb_udp_packet_builder_n6.sv
// Self-checking bench for udp_packet_builder_n6: byte-level frame model, per-word compare, directed literal checks.
module tb_udp_packet_builder_n6;

  logic        CLK = 1'b0;
  logic        reset;
  logic        hdr_valid_i, hdr_ready_o;
  logic [47:0] dst_mac_i, src_mac_i;
  logic [31:0] src_ip_i, dst_ip_i;
  logic [7:0]  tos_i, ttl_i;
  logic [15:0] src_port_i, dst_port_i, pay_len_i;
  logic [31:0] pay_data_i;
  logic        pay_valid_i, pay_last_i, pay_ready_o;
  logic [31:0] tx_data_o;
  logic        tx_valid_o, tx_ready_i, tx_sop_o, tx_eop_o, len_err_o;
  logic [2:0]  tx_bytes_o;

  udp_packet_builder_n6 dut (
    .CLK(CLK), .reset(reset),
    .hdr_valid_i(hdr_valid_i), .hdr_ready_o(hdr_ready_o),
    .dst_mac_i(dst_mac_i), .src_mac_i(src_mac_i), .src_ip_i(src_ip_i), .dst_ip_i(dst_ip_i),
    .tos_i(tos_i), .ttl_i(ttl_i), .src_port_i(src_port_i), .dst_port_i(dst_port_i),
    .pay_len_i(pay_len_i), .pay_data_i(pay_data_i), .pay_valid_i(pay_valid_i),
    .pay_last_i(pay_last_i), .pay_ready_o(pay_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .tx_sop_o(tx_sop_o), .tx_eop_o(tx_eop_o), .tx_bytes_o(tx_bytes_o), .len_err_o(len_err_o)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  bytes;
  } word_t;

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          cyc      = 0;
  int          err_cnt  = 0;
  int          cap_n    = 0;
  int          frames_done = 0;
  int          sop_cyc  = 0;
  int          acc_cyc  = 0;
  logic [31:0] cap_w [0:511];
  logic [2:0]  last_bytes_cap;
  word_t       exp_q [$];
  logic [15:0] model_id;
  logic [7:0]  pay_b [0:2047];
  logic        rnd_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
  endtask

  // IPv4 header checksum from the header field values (plain arithmetic, end-around carry).
  function automatic logic [15:0] model_csum(input int len);
`ifdef PKT_BUILDER_IPV4_CSUM_EN
    int unsigned s;
    logic [15:0] r;
    s = 32'h4500 + tos_i + 32'(len + 28) + model_id + (ttl_i * 256 + 17)
      + src_ip_i[31:16] + src_ip_i[15:0] + dst_ip_i[31:16] + dst_ip_i[15:0];
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    r = s[15:0];
    return ~r;
`else
    return 16'h0000 + 16'(len & 0);
`endif
  endfunction

  // Builds the expected frame as a byte list, then slices it into bus words.
  task automatic model_push(input int len);
    logic [7:0]  fb [$];
    logic [15:0] tot, udp, cs;
    int          total;
    word_t       w;
    tot = 16'(len + 28);
    udp = 16'(len + 8);
    cs  = model_csum(len);
    for (int i = 5; i >= 0; i--) fb.push_back(dst_mac_i[8*i +: 8]);
    for (int i = 5; i >= 0; i--) fb.push_back(src_mac_i[8*i +: 8]);
    fb.push_back(8'h08); fb.push_back(8'h00);
    fb.push_back(8'h45); fb.push_back(tos_i);
    fb.push_back(tot[15:8]); fb.push_back(tot[7:0]);
    fb.push_back(model_id[15:8]); fb.push_back(model_id[7:0]);
    fb.push_back(8'h00); fb.push_back(8'h00);
    fb.push_back(ttl_i); fb.push_back(8'd17);
    fb.push_back(cs[15:8]); fb.push_back(cs[7:0]);
    for (int i = 3; i >= 0; i--) fb.push_back(src_ip_i[8*i +: 8]);
    for (int i = 3; i >= 0; i--) fb.push_back(dst_ip_i[8*i +: 8]);
    fb.push_back(src_port_i[15:8]); fb.push_back(src_port_i[7:0]);
    fb.push_back(dst_port_i[15:8]); fb.push_back(dst_port_i[7:0]);
    fb.push_back(udp[15:8]); fb.push_back(udp[7:0]);
    fb.push_back(8'h00); fb.push_back(8'h00);
    for (int i = 0; i < len; i++) fb.push_back(pay_b[i]);
    total = 42 + len;
    for (int wi = 0; wi * 4 < total; wi++) begin
      w.data = 32'h0;
      for (int b = 0; b < 4; b++)
        w.data = {w.data[23:0], ((4*wi + b) < total) ? fb[4*wi + b] : 8'h00};
      w.sop   = (wi == 0);
      w.eop   = (4*wi + 4 >= total);
      w.bytes = w.eop ? 3'(total - 4*wi) : 3'd4;
      exp_q.push_back(w);
    end
    model_id = model_id + 16'd1;
  endtask

  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(posedge CLK);
      #1 tx_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Compare process: every transferred word against the model, and held words while stalled.
  initial begin
    logic  prev_stall = 1'b0, prev_reset = 1'b1, prev_err = 1'b0, in_frame = 1'b0;
    word_t prev_w = '0, cur, w;
    forever begin
      @(negedge CLK);
      if (len_err_o) begin
        err_cnt++;
        check("len_err_single_pulse", 64'(prev_err), 64'(0));
      end
      prev_err = len_err_o;
      cur = {tx_data_o, tx_sop_o, tx_eop_o, tx_bytes_o};
      if (prev_stall && !prev_reset)
        check("stall_hold", 64'({tx_valid_o, cur}), 64'({1'b1, prev_w}));
      if (tx_valid_o && tx_sop_o && !in_frame) begin
        in_frame = 1'b1;
        sop_cyc  = cyc;
      end
      if (tx_valid_o && tx_ready_i && !reset) begin
        if (exp_q.size() == 0) check("unexpected_word", 64'({1'b1, cur}), 64'(0));
        else begin
          w = exp_q.pop_front();
          check("tx_word", 64'(cur), 64'(w));
        end
        if (tx_sop_o) cap_n = 0;
        if (cap_n < 512) cap_w[cap_n] = tx_data_o;
        cap_n++;
        if (tx_eop_o) begin
          last_bytes_cap = tx_bytes_o;
          frames_done++;
          in_frame = 1'b0;
        end
      end
      prev_stall = tx_valid_o && !tx_ready_i;
      prev_w     = cur;
      prev_reset = reset;
      if (reset) in_frame = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic set_desc();
    dst_mac_i  = 48'h02_00_00_00_00_02;
    src_mac_i  = 48'h02_00_00_00_00_01;
    src_ip_i   = 32'h0A00_0001;
    dst_ip_i   = 32'h0A00_0002;
    tos_i      = 8'h00;
    ttl_i      = 8'd64;
    src_port_i = 16'h1234;
    dst_port_i = 16'h5678;
  endtask

  task automatic fill_payload(input int len, input int seed);
    for (int i = 0; i < len; i++) pay_b[i] = 8'(i * 7 + seed);
    for (int i = len; i < len + 4; i++) pay_b[i] = 8'hEE;
  endtask

  task automatic send_desc(input int len);
    logic ok = 1'b0;
    pay_len_i   = 16'(len);
    hdr_valid_i = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      if (hdr_ready_o) begin
        ok      = 1'b1;
        acc_cyc = cyc + 1;
      end
      @(posedge CLK);
      #1;
    end
    check("hdr_accept", 64'(ok), 64'(1));
    hdr_valid_i = 1'b0;
    if (ok && len >= 1 && len <= 1472) model_push(len);
  endtask

  task automatic drive_payload(input int len, input int gap_k, input int gap_len,
                               input int last_k, input int stop_k);
    int   nw;
    logic ok;
    nw = (len + 3) / 4;
    for (int k = 0; k < nw && k < stop_k; k++) begin
      if (k == gap_k) begin
        pay_valid_i = 1'b0;
        repeat (gap_len) begin
          @(negedge CLK);
          check("gap_tx_valid_low", 64'(tx_valid_o), 64'(0));
          @(posedge CLK);
          #1;
        end
      end
      pay_data_i  = {pay_b[4*k], pay_b[4*k+1], pay_b[4*k+2], pay_b[4*k+3]};
      pay_last_i  = (k == last_k);
      pay_valid_i = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
        @(negedge CLK);
        ok = pay_ready_o;
        @(posedge CLK);
        #1;
      end
      check("pay_accept", 64'(ok), 64'(1));
    end
    pay_valid_i = 1'b0;
    pay_last_i  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge CLK);
    check("frame_drained", 64'(exp_q.size()), 64'(0));
    @(posedge CLK);
    #1;
  endtask

  task automatic run_frame(input int len, input int gap_k, input int gap_len, input int last_k);
    send_desc(len);
    drive_payload(len, gap_k, gap_len, last_k, 1 << 30);
    wait_drain();
  endtask

  task automatic check_frame_a(input string tag, input logic [15:0] id);
    logic [15:0] csum_lit;
`ifdef PKT_BUILDER_IPV4_CSUM_EN
    csum_lit = (id == 16'h0000) ? 16'h66CB : 16'hXXXX;
`else
    csum_lit = 16'h0000;
`endif
    check({tag, "_words"}, 64'(cap_n), 64'(12));
    check({tag, "_w0"}, 64'(cap_w[0]), 64'h0200_0000);
    check({tag, "_w1"}, 64'(cap_w[1]), 64'h0002_0200);
    check({tag, "_w2"}, 64'(cap_w[2]), 64'h0000_0001);
    check({tag, "_w3"}, 64'(cap_w[3]), 64'h0800_4500);
    check({tag, "_w4_totlen_id"}, 64'(cap_w[4]), 64'({16'h0020, id}));
    check({tag, "_w5"}, 64'(cap_w[5]), 64'h0000_4011);
    check({tag, "_w6_csum"}, 64'(cap_w[6]), 64'({csum_lit, 16'h0A00}));
    check({tag, "_w7"}, 64'(cap_w[7]), 64'h0001_0A00);
    check({tag, "_w8"}, 64'(cap_w[8]), 64'h0002_1234);
    check({tag, "_w9"}, 64'(cap_w[9]), 64'h5678_000C);
    check({tag, "_w10"}, 64'(cap_w[10]), 64'h0000_A1B2);
    check({tag, "_w11"}, 64'(cap_w[11]), 64'hC3D4_0000);
    check({tag, "_last_bytes"}, 64'(last_bytes_cap), 64'(2));
  endtask

  initial begin
    int exp_bytes [5] = '{3, 4, 1, 2, 3};
    int exp_words [5] = '{11, 11, 12, 12, 12};
    int e0;
    reset = 1'b1; hdr_valid_i = 1'b0; pay_valid_i = 1'b0; pay_last_i = 1'b0;
    pay_data_i = 32'h0; pay_len_i = 16'd0;
    set_desc();
    model_id = 16'h0000;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs",
          64'({tx_valid_o, tx_sop_o, tx_eop_o, len_err_o, pay_ready_o, tx_data_o, tx_bytes_o}),
          64'({5'b00000, 32'h0, 3'd4}));
    @(posedge CLK);
    #1 reset = 1'b0;
    @(negedge CLK);
    check("hdr_ready_after_reset", 64'(hdr_ready_o), 64'(1));
    @(posedge CLK);
    #1;

    // Directed L=4 frame with hand-computed words.
    pay_b[0] = 8'hA1; pay_b[1] = 8'hB2; pay_b[2] = 8'hC3; pay_b[3] = 8'hD4;
    run_frame(4, -1, 0, 0);
    check_frame_a("A", 16'h0000);
    check("sop_latency", 64'(sop_cyc - acc_cyc), 64'(1));

    // Length sweep: last-word byte count and word count (TAIL only for L=3,4).
    for (int l = 1; l <= 5; l++) begin
      fill_payload(l, l * 13);
      run_frame(l, -1, 0, (l + 3) / 4 - 1);
      check($sformatf("sweep_L%0d_bytes", l), 64'(last_bytes_cap), 64'(exp_bytes[l-1]));
      check($sformatf("sweep_L%0d_words", l), 64'(cap_n), 64'(exp_words[l-1]));
    end
    check("no_len_err_clean_frames", 64'(err_cnt), 64'(0));

    // Random back-pressure on a 64-byte payload.
    rnd_ready = 1'b1;
    fill_payload(64, 5);
    run_frame(64, -1, 0, 15);
    rnd_ready = 1'b0;
    @(posedge CLK);
    #1;

    // Payload source gap of 5 cycles mid-frame.
    fill_payload(40, 99);
    run_frame(40, 5, 5, 9);

    // pay_last on the first of three words: one pulse, frame length still from L.
    e0 = err_cnt;
    fill_payload(12, 3);
    run_frame(12, -1, 0, 0);
    check("bad_last_err_pulses", 64'(err_cnt - e0), 64'(1));
    check("bad_last_words", 64'(cap_n), 64'(14));

    // Illegal lengths: dropped with one pulse each, no output.
    e0 = err_cnt;
    send_desc(0);
    repeat (4) @(posedge CLK);
    #1;
    check("len0_err_pulse", 64'(err_cnt - e0), 64'(1));
    send_desc(1473);
    repeat (4) @(posedge CLK);
    #1;
    check("len1473_err_pulse", 64'(err_cnt - e0), 64'(2));
    check("drop_ready_again", 64'(hdr_ready_o), 64'(1));

    // Reset during PAYLOAD, then a fresh frame restarts ip_id.
    fill_payload(40, 21);
    send_desc(40);
    @(negedge CLK);
    check("hdr_held_off", 64'(hdr_ready_o), 64'(0));
    @(posedge CLK);
    #1;
    drive_payload(40, -1, 0, 9, 3);
    reset = 1'b1;
    @(posedge CLK);
    #1 reset = 1'b0;
    exp_q.delete();
    model_id = 16'h0000;
    @(negedge CLK);
    check("mid_frame_reset_outputs",
          64'({tx_valid_o, tx_sop_o, tx_eop_o, len_err_o, pay_ready_o, tx_data_o, tx_bytes_o, hdr_ready_o}),
          64'({5'b00000, 32'h0, 3'd4, 1'b1}));
    @(posedge CLK);
    #1;
    pay_b[0] = 8'hA1; pay_b[1] = 8'hB2; pay_b[2] = 8'hC3; pay_b[3] = 8'hD4;
    run_frame(4, -1, 0, 0);
    check_frame_a("R", 16'h0000);

    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
